// File: rtl/seg_tick_counter.sv
// N-digit hex/BCD up/down counter stepped by a prescaled tick, with registered
// seven-segment outputs for every digit.
module seg_tick_counter #(
  parameter int NUM_DIGITS     = 2,
  parameter int CLK_HZ         = 10_000_000,
  parameter int TICK_HZ        = 1,
  parameter bit BCD            = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [8*NUM_DIGITS-1:0] seg,
  output logic                    tick,
  output logic                    wrap
);

  localparam int              DIV        = CLK_HZ / TICK_HZ;
  localparam int              PW         = $clog2(DIV);
  localparam int              CW         = 4 * NUM_DIGITS;
  localparam int              SW         = 8 * NUM_DIGITS;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
  localparam logic [3:0]      DIGIT_MAX  = BCD ? 4'd9 : 4'd15;

  logic [PW-1:0] presc_r;
  logic [PW-1:0] presc_next_s;
  logic          tick_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] step_s;
  logic          carry_s;
  logic [3:0]    digit_s;
  logic          wrap_r;
  logic [SW-1:0] seg_r;

  // Table codes are active-low {dp,g,f,e,d,c,b,a}; dp stays off.
  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    logic [7:0] code;
    case (digit)
      4'h0:    code = 8'hC0;
      4'h1:    code = 8'hF9;
      4'h2:    code = 8'hA4;
      4'h3:    code = 8'hB0;
      4'h4:    code = 8'h99;
      4'h5:    code = 8'h92;
      4'h6:    code = 8'h82;
      4'h7:    code = 8'hF8;
      4'h8:    code = 8'h80;
      4'h9:    code = 8'h90;
      4'hA:    code = 8'h88;
      4'hB:    code = 8'h83;
      4'hC:    code = 8'hC6;
      4'hD:    code = 8'hA1;
      4'hE:    code = 8'h86;
      4'hF:    code = 8'h8E;
      default: code = 8'hFF;
    endcase
    if (SEG_ACTIVE_LOW) begin
      return code;
    end else begin
      return ~code;
    end
  endfunction

  function automatic logic [SW-1:0] seg_all(input logic [CW-1:0] value);
    logic [SW-1:0] res;
    res = {SW{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      res[8*i +: 8] = seg_encode(value[4*i +: 4]);
    end
    return res;
  endfunction

  // In BCD mode a nibble above 9 saturates to 9 rather than becoming an illegal digit.
  function automatic logic [CW-1:0] clamp_load(input logic [CW-1:0] value);
    logic [CW-1:0] res;
    res = {CW{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (BCD && (value[4*i +: 4] > 4'd9)) begin
        res[4*i +: 4] = 4'd9;
      end else begin
        res[4*i +: 4] = value[4*i +: 4];
      end
    end
    return res;
  endfunction

  // Prescaler successor: free-running modulo DIV.
  always_comb begin
    if (presc_r == PRESC_LAST) begin
      presc_next_s = {PW{1'b0}};
    end else begin
      presc_next_s = presc_r + PW'(1);
    end
  end

  // Ripple carry/borrow through all digits; a carry out of the top digit is a wrap.
  always_comb begin
    step_s  = count_r;
    carry_s = 1'b1;
    digit_s = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_s = count_r[4*i +: 4];
      if (!carry_s) begin
        step_s[4*i +: 4] = digit_s;
      end else if (up) begin
        if (digit_s == DIGIT_MAX) begin
          step_s[4*i +: 4] = 4'd0;
        end else begin
          step_s[4*i +: 4] = digit_s + 4'd1;
          carry_s          = 1'b0;
        end
      end else begin
        if (digit_s == 4'd0) begin
          step_s[4*i +: 4] = DIGIT_MAX;
        end else begin
          step_s[4*i +: 4] = digit_s - 4'd1;
          carry_s          = 1'b0;
        end
      end
    end
  end

  // Prescaler and tick: tick is high exactly while the prescaler sits at DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= {PW{1'b0}};
      tick_r  <= 1'b0;
    end else if (clr) begin
      presc_r <= {PW{1'b0}};
      tick_r  <= 1'b0;
    end else begin
      presc_r <= presc_next_s;
      tick_r  <= (presc_next_s == PRESC_LAST);
    end
  end

  // Count and wrap: clr beats load beats a tick step; en is only looked at on tick cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
      wrap_r  <= 1'b0;
    end else if (clr) begin
      count_r <= {CW{1'b0}};
      wrap_r  <= 1'b0;
    end else if (load) begin
      count_r <= clamp_load(load_val);
      wrap_r  <= 1'b0;
    end else if (tick_r && en) begin
      count_r <= step_s;
      wrap_r  <= carry_s;
    end else begin
      count_r <= count_r;
      wrap_r  <= 1'b0;
    end
  end

  // Segment register trails the count by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r <= seg_all({CW{1'b0}});
    end else begin
      seg_r <= seg_all(count_r);
    end
  end

  assign count = count_r;
  assign seg   = seg_r;
  assign tick  = tick_r;
  assign wrap  = wrap_r;

endmodule

// File: tb/tb_seg_tick_counter.sv
// Randomised bench for seg_tick_counter: a hex/active-low and a BCD/active-high
// instance share stimulus and are compared every cycle against an arithmetic model.
module tb_seg_tick_counter;

  localparam int ND  = 2;
  localparam int DIV = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            up;
  logic            clr;
  logic            load;
  logic [4*ND-1:0] load_val;
  logic [4*ND-1:0] count_h, count_b;
  logic [8*ND-1:0] seg_h, seg_b;
  logic            tick_h, tick_b, wrap_h, wrap_b;

  always #5 clk = ~clk;

  seg_tick_counter #(.NUM_DIGITS(ND), .CLK_HZ(10), .TICK_HZ(1), .BCD(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut_hex (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .count(count_h), .seg(seg_h), .tick(tick_h), .wrap(wrap_h));

  seg_tick_counter #(.NUM_DIGITS(ND), .CLK_HZ(10), .TICK_HZ(1), .BCD(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut_bcd (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .count(count_b), .seg(seg_b), .tick(tick_b), .wrap(wrap_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0] seg_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model state: prescaler phase, counts as plain integers (m=0 hex, m=1 decimal).
  int              phase;
  int              mval [2];
  bit              mwrap [2];
  bit              mtick;
  logic [8*ND-1:0] mseg [2];

  function automatic int radix(int m);
    return (m == 1) ? 10 : 16;
  endfunction

  function automatic int modulus(int m);
    int r = 1;
    for (int i = 0; i < ND; i++) r = r * radix(m);
    return r;
  endfunction

  function automatic logic [4*ND-1:0] to_digits(int m, int v);
    logic [4*ND-1:0] r;
    int rem = v;
    int d;
    for (int i = 0; i < ND; i++) begin
      d = rem % radix(m);
      r[4*i +: 4] = d[3:0];
      rem = rem / radix(m);
    end
    return r;
  endfunction

  function automatic int from_load(int m, logic [4*ND-1:0] lv);
    int v = 0;
    int p = 1;
    int d;
    for (int i = 0; i < ND; i++) begin
      d = int'(lv[4*i +: 4]);
      if (m == 1 && d > 9) d = 9;
      v = v + d * p;
      p = p * radix(m);
    end
    return v;
  endfunction

  function automatic logic [8*ND-1:0] seg_of(int m, logic [4*ND-1:0] c);
    logic [8*ND-1:0] r;
    for (int i = 0; i < ND; i++) begin
      r[8*i +: 8] = (m == 1) ? ~seg_lut[c[4*i +: 4]] : seg_lut[c[4*i +: 4]];
    end
    return r;
  endfunction

  task automatic model_reset();
    phase = 0;
    mtick = 1'b0;
    for (int m = 0; m < 2; m++) begin
      mval[m]  = 0;
      mwrap[m] = 1'b0;
      mseg[m]  = seg_of(m, to_digits(m, 0));
    end
  endtask

  task automatic model_edge();
    bit t_old;
    int nv;
    t_old = mtick;
    for (int m = 0; m < 2; m++) mseg[m] = seg_of(m, to_digits(m, mval[m]));
    if (clr) begin
      phase = 0;
      mtick = 1'b0;
      for (int m = 0; m < 2; m++) begin
        mval[m]  = 0;
        mwrap[m] = 1'b0;
      end
    end else begin
      phase = (phase + 1) % DIV;
      mtick = (phase == DIV - 1);
      for (int m = 0; m < 2; m++) begin
        if (load) begin
          mval[m]  = from_load(m, load_val);
          mwrap[m] = 1'b0;
        end else if (t_old && en) begin
          nv       = up ? mval[m] + 1 : mval[m] - 1;
          mwrap[m] = (nv < 0) || (nv >= modulus(m));
          mval[m]  = (nv + modulus(m)) % modulus(m);
        end else begin
          mwrap[m] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    check("hex_count", 32'(count_h), 32'(to_digits(0, mval[0])));
    check("hex_seg",   32'(seg_h),   32'(mseg[0]));
    check("hex_tick",  32'(tick_h),  32'(mtick));
    check("hex_wrap",  32'(wrap_h),  32'(mwrap[0]));
    check("bcd_count", 32'(count_b), 32'(to_digits(1, mval[1])));
    check("bcd_seg",   32'(seg_b),   32'(mseg[1]));
    check("bcd_tick",  32'(tick_b),  32'(mtick));
    check("bcd_wrap",  32'(wrap_b),  32'(mwrap[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check("rst_seg_hex", 32'(seg_h), 32'h0000C0C0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int ntick;

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    #12;
    model_reset();
    check_all();
    check("reset_seg_hex", 32'(seg_h), 32'h0000C0C0);
    check("reset_seg_bcd", 32'(seg_b), 32'h00003F3F);
    @(negedge clk);
    rst = 1'b0;

    // Count up from reset for 16 ticks.
    en = 1'b1; up = 1'b1;
    repeat (160) step();
    check("sixteen_ticks_hex", 32'(count_h), 32'h10);
    check("sixteen_ticks_bcd", 32'(count_b), 32'h16);

    // Load max then tick up through the wrap.
    load = 1'b1; load_val = 8'hFF;
    step();
    load = 1'b0;
    check("bcd_clamp_ff", 32'(count_b), 32'h99);
    repeat (12) step();

    // Decimal clamp of an illegal load, then count down through zero.
    load = 1'b1; load_val = 8'hAB;
    step();
    load = 1'b0;
    check("bcd_clamp_ab", 32'(count_b), 32'h99);
    check("hex_load_ab", 32'(count_h), 32'hAB);
    load = 1'b1; load_val = 8'h00;
    step();
    load = 1'b0; up = 1'b0;
    repeat (12) step();
    load = 1'b1; load_val = 8'h10;
    step();
    load = 1'b0;
    repeat (12) step();

    // clr together with load: clr wins, prescaler restarts.
    clr = 1'b1; load = 1'b1; load_val = 8'h55;
    step();
    clr = 1'b0; load = 1'b0;
    check("clr_over_load", 32'(count_h), 32'h00);
    load = 1'b1; load_val = 8'h37;
    step();
    load = 1'b0; en = 1'b0;
    ntick = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      ntick += int'(tick_h);
    end
    check("en_off_ticks", 32'(ntick), 32'd3);
    check("en_off_hold", 32'(count_h), 32'h37);
    repeat (4) step();
    async_reset();

    // Randomised run.
    up = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      clr  = ($urandom_range(59, 0) == 0);
      load = ($urandom_range(24, 0) == 0);
      case ($urandom_range(3, 0))
        0:       load_val = 8'hFF;
        1:       load_val = 8'h99;
        2:       load_val = 8'h00;
        default: load_val = 8'($urandom);
      endcase
      en = ($urandom_range(4, 0) != 0);
      if ($urandom_range(39, 0) == 0) up = ~up;
      step();
      if (i == 1500) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
